// File: rtl/dlf16_int_accumulator.sv
// Packet-summing int32 accumulator behind the DLFloat16-to-int32 converter.
// Define DLF16_ACC_SAT_EN to saturate out_sum instead of wrapping it.
module dlf16_int_accumulator #(
  parameter int unsigned ACC_W = 48,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [31:0]       out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {ACC, HOLD} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_sat;

  logic [ACC_W-1:0]   acc_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               sat_nxt;
  logic               cnt_max;
  logic [ACC_W-32:0]  acc_hi;
  logic               ovf_range;
  logic [31:0]        sum_sel;
  logic               accept;

  assign in_ready = (state == ACC) && !rst;
  assign accept   = in_valid && in_ready;

  assign acc_nxt = acc + {{(ACC_W-32){in_data[31]}}, in_data};
  assign cnt_max = &cnt;
  assign cnt_nxt = cnt_max ? cnt : cnt + CNT_W'(1);
  assign sat_nxt = cnt_sat | cnt_max;

  // Sum fits int32 only when bits [ACC_W-1:31] are all equal
  assign acc_hi    = acc_nxt[ACC_W-1:31];
  assign ovf_range = (|acc_hi) && !(&acc_hi);

`ifdef DLF16_ACC_SAT_EN
  always_comb begin
    sum_sel = acc_nxt[31:0];
    if (ovf_range)
      sum_sel = acc_nxt[ACC_W-1] ? 32'h8000_0000 : 32'h7fff_ffff;
  end
`else
  assign sum_sel = acc_nxt[31:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      cnt_sat   <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        ACC: begin
          if (accept) begin
            if (in_last) begin
              out_sum   <= sum_sel;
              out_count <= cnt_nxt;
              out_ovf   <= ovf_range | sat_nxt;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              cnt_sat   <= 1'b0;
              state     <= HOLD;
            end else begin
              acc     <= acc_nxt;
              cnt     <= cnt_nxt;
              cnt_sat <= sat_nxt;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_dlf16_int_accumulator.sv
// Directed bench for dlf16_int_accumulator: packet table plus
// hand-written backpressure, reset and valid-gap sequences.
module tb_dlf16_int_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_sum;
  logic [15:0] out_count;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  dlf16_int_accumulator #(.ACC_W(48), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    string            name;
    int               n;
    logic [2:0][31:0] d;
    logic [31:0]      sum;
    logic [15:0]      cnt;
    logic             ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for in_ready, let it be accepted
  task automatic beat(input logic [31:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    out_ready = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      beat(v.d[i], i == v.n - 1);
      if (i < v.n - 1)
        chk({v.name, "_early_valid"}, {63'd0, out_valid}, 64'd0);
    end
    chk({v.name, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({v.name, "_sum"},   {32'd0, out_sum},   {32'd0, v.sum});
    chk({v.name, "_count"}, {48'd0, out_count}, {48'd0, v.cnt});
    chk({v.name, "_ovf"},   {63'd0, out_ovf},   {63'd0, v.ovf});
    out_ready = 1'b1;
    tick();
    chk({v.name, "_drop"}, {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"basic", 3, {32'd100, -32'sd3, 32'd5},
                32'd102, 16'd3, 1'b0};
`ifdef DLF16_ACC_SAT_EN
    vecs[1] = '{"pos_ovf", 2, {32'd0, 32'h7fff_ffff, 32'h7fff_ffff},
                32'h7fff_ffff, 16'd2, 1'b1};
    vecs[2] = '{"neg_ovf", 2, {32'd0, 32'hffff_ffff, 32'h8000_0000},
                32'h8000_0000, 16'd2, 1'b1};
`else
    vecs[1] = '{"pos_ovf", 2, {32'd0, 32'h7fff_ffff, 32'h7fff_ffff},
                32'hffff_fffe, 16'd2, 1'b1};
    vecs[2] = '{"neg_ovf", 2, {32'd0, 32'hffff_ffff, 32'h8000_0000},
                32'h7fff_ffff, 16'd2, 1'b1};
`endif
    vecs[3] = '{"single", 1, {32'd0, 32'd0, 32'd42},
                32'd42, 16'd1, 1'b0};
    vecs[4] = '{"max_edge", 3, {32'hffff_ffff, 32'd1, 32'h7fff_ffff},
                32'h7fff_ffff, 16'd3, 1'b0};
    vecs[5] = '{"min_edge", 1, {32'd0, 32'd0, 32'h8000_0000},
                32'h8000_0000, 16'd1, 1'b0};

    rst = 1'b1; in_data = '0; in_valid = 1'b0;
    in_last = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_valid",    {63'd0, out_valid}, 64'd0);
    chk("rst_sum",      {32'd0, out_sum},  64'd0);
    chk("rst_count",    {48'd0, out_count}, 64'd0);
    chk("rst_ovf",      {63'd0, out_ovf},  64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure with the next packet already waiting
    beat(32'd7, 1'b1);
    in_valid = 1'b1; in_data = 32'd1; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_valid",    {63'd0, out_valid}, 64'd1);
      chk("bp_sum",      {32'd0, out_sum},  64'd7);
      chk("bp_count",    {48'd0, out_count}, 64'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", {63'd0, out_valid}, 64'd0);
    beat(32'd1, 1'b0);
    beat(32'd1, 1'b1);
    chk("bp2_valid", {63'd0, out_valid}, 64'd1);
    chk("bp2_sum",   {32'd0, out_sum},   64'd2);
    chk("bp2_count", {48'd0, out_count}, 64'd2);
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a packet
    beat(32'd10, 1'b0);
    beat(32'd20, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_sum",   {32'd0, out_sum},   64'd0);
    chk("mid_rst_count", {48'd0, out_count}, 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_rel", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_ovf", {63'd0, out_ovf},  64'd0);
    beat(32'd4, 1'b1);
    chk("after_rst_sum",   {32'd0, out_sum},   64'd4);
    chk("after_rst_count", {48'd0, out_count}, 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Idle gaps carry junk that must be ignored
    beat(-32'sd8, 1'b0);
    in_data = 32'h1234_5678; in_last = 1'b1;
    repeat (2) tick();
    beat(32'd3, 1'b0);
    in_data = 32'hdead_beef; in_last = 1'b1;
    repeat (2) tick();
    chk("gap_valid_mid", {63'd0, out_valid}, 64'd0);
    beat(-32'sd2, 1'b1);
    chk("gap_sum",   {32'd0, out_sum},   {32'd0, 32'hffff_fff9});
    chk("gap_count", {48'd0, out_count}, 64'd3);
    chk("gap_ovf",   {63'd0, out_ovf},   64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
